// File: rtl/full_st0_ctrl_seq_if.sv
// Stage-0 FC sequencer bus: request levels, stall and error strobes in; schedule out.
// Latency: n/a (wiring only).
// Backpressure: out_rdy from the consumer stalls forward issue.
interface full_st0_ctrl_seq_if;
    logic       data_ready;
    logic       err_ready;
    logic       out_rdy;
    logic       error_valid;
    logic       active_normal;
    logic       active_pre;
    logic       active;
    logic       active_start_d;
    logic [3:0] tap_address;
    logic [5:0] data_read_addr;
    logic       error_update_first;
    logic       error_update_latch;
    logic [1:0] error_phase_read;
    logic [1:0] error_phase;
    logic       read_finish;
    logic       busy;

    // Requester / consumer side: raises requests, applies stall, reads the schedule.
    modport master (
        output data_ready, err_ready, out_rdy, error_valid,
        input  active_normal, active_pre, active, active_start_d,
        input  tap_address, data_read_addr,
        input  error_update_first, error_update_latch,
        input  error_phase_read, error_phase, read_finish, busy
    );

    // Sequencer side.
    modport slave (
        input  data_ready, err_ready, out_rdy, error_valid,
        output active_normal, active_pre, active, active_start_d,
        output tap_address, data_read_addr,
        output error_update_first, error_update_latch,
        output error_phase_read, error_phase, read_finish, busy
    );
endinterface

// File: rtl/full_st0_ctrl_seq.sv
// Stage-0 FC sequencer: forward tap x data read pass, then error/update pass, then drain.
// Latency: schedule outputs registered 1 cycle after the FSM decision; active* delayed PIPE_LAT.
// Backpressure: out_rdy=0 holds forward counters and issues a bubble; error pass never stalls.
module full_st0_ctrl_seq #(
    parameter int TAP_ROWS   = 12,
    parameter int DATA_LEN   = 64,
    parameter int PIPE_LAT   = 5,
    parameter int ERR_PHASES = 4
) (
    input  logic                clk,
    input  logic                reset,
    full_st0_ctrl_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FWD, ERR_FIRST, ERR_UPD, DRAIN} state_t;

    state_t     state;
    logic [3:0] tap_cnt;
    logic [5:0] data_cnt;
    logic [1:0] phase_cnt;
    logic [3:0] drain_cnt;

    logic       active_normal_q;
    logic       fwd_issue_q;
    logic [3:0] tap_q;
    logic [5:0] data_q;
    logic       first_q;
    logic       latch_q;
    logic [1:0] phase_read_q;
    logic       finish_q;
    logic [1:0] err_phase_q;

    logic [PIPE_LAT-2:0] norm_sr;
    logic [PIPE_LAT-1:0] fwd_sr;
    logic [PIPE_LAT-1:0] start_sr;
    logic                start_now;

    // Pass start marker only means something for forward reads, where (0,0) is the first pair.
    assign start_now = fwd_issue_q && (tap_q == 4'd0) && (data_q == 6'd0);

    // Schedule FSM: counters plus registered issue outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            tap_cnt         <= '0;
            data_cnt        <= '0;
            phase_cnt       <= '0;
            drain_cnt       <= '0;
            active_normal_q <= 1'b0;
            fwd_issue_q     <= 1'b0;
            tap_q           <= '0;
            data_q          <= '0;
            first_q         <= 1'b0;
            latch_q         <= 1'b0;
            phase_read_q    <= '0;
            finish_q        <= 1'b0;
        end else begin
            active_normal_q <= 1'b0;
            fwd_issue_q     <= 1'b0;
            first_q         <= 1'b0;
            latch_q         <= 1'b0;
            finish_q        <= 1'b0;
            case (state)
                IDLE: begin
                    tap_cnt   <= '0;
                    data_cnt  <= '0;
                    phase_cnt <= '0;
                    drain_cnt <= '0;
                    if (bus.err_ready) begin
                        state <= ERR_FIRST;
                    end else if (bus.data_ready) begin
                        state <= FWD;
                    end
                end
                FWD: begin
                    if (bus.out_rdy) begin
                        active_normal_q <= 1'b1;
                        fwd_issue_q     <= 1'b1;
                        tap_q           <= tap_cnt;
                        data_q          <= data_cnt;
                        if (tap_cnt == 4'(TAP_ROWS - 1)) begin
                            tap_cnt  <= '0;
                            data_cnt <= data_cnt + 6'd1;
                            if (data_cnt == 6'(DATA_LEN - 1)) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            tap_cnt <= tap_cnt + 4'd1;
                        end
                    end
                end
                ERR_FIRST: begin
                    active_normal_q <= 1'b1;
                    first_q         <= 1'b1;
                    latch_q         <= 1'b1;
                    phase_read_q    <= phase_cnt;
                    tap_q           <= 4'(TAP_ROWS) + {2'b00, phase_cnt};
                    if (phase_cnt == 2'(ERR_PHASES - 1)) begin
                        phase_cnt <= '0;
                        tap_cnt   <= '0;
                        state     <= ERR_UPD;
                    end else begin
                        phase_cnt <= phase_cnt + 2'd1;
                    end
                end
                ERR_UPD: begin
                    active_normal_q <= 1'b1;
                    latch_q         <= 1'b1;
                    tap_q           <= tap_cnt;
                    if (tap_cnt == 4'(TAP_ROWS - 1)) begin
                        tap_cnt   <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        tap_cnt <= tap_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    // Wait out the datapath so the last result lands before read_finish.
                    if (drain_cnt == 4'(PIPE_LAT)) begin
                        finish_q  <= 1'b1;
                        drain_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay lines aligning issue markers with datapath output; they shift every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            norm_sr  <= '0;
            fwd_sr   <= '0;
            start_sr <= '0;
        end else begin
            norm_sr  <= {norm_sr[PIPE_LAT-3:0], active_normal_q};
            fwd_sr   <= {fwd_sr[PIPE_LAT-2:0], fwd_issue_q};
            start_sr <= {start_sr[PIPE_LAT-2:0], start_now};
        end
    end

    // Incoming error write phase, independent of the pass state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_phase_q <= '0;
        end else if (bus.error_valid) begin
            err_phase_q <= (err_phase_q == 2'(ERR_PHASES - 1)) ? 2'd0 : err_phase_q + 2'd1;
        end
    end

    assign bus.active_normal      = active_normal_q;
    assign bus.active_pre         = norm_sr[PIPE_LAT-2];
    assign bus.active             = fwd_sr[PIPE_LAT-1];
    assign bus.active_start_d     = start_sr[PIPE_LAT-1];
    assign bus.tap_address        = tap_q;
    assign bus.data_read_addr     = data_q;
    assign bus.error_update_first = first_q;
    assign bus.error_update_latch = latch_q;
    assign bus.error_phase_read   = phase_read_q;
    assign bus.error_phase        = err_phase_q;
    assign bus.read_finish        = finish_q;
    assign bus.busy               = (state != IDLE);
endmodule

// File: tb/tb_full_st0_ctrl_seq.sv
// Directed bench for the stage-0 FC sequencer.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: drives out_rdy low for a 3-cycle stall inside a forward pass.
module tb_full_st0_ctrl_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    full_st0_ctrl_seq_if bus();

    full_st0_ctrl_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] flags();
        return {bus.active_normal, bus.active_pre, bus.active, bus.active_start_d,
                bus.error_update_first, bus.error_update_latch, bus.read_finish, bus.busy};
    endfunction

    // Per-pass observations
    int p_first, p_last, p_start, p_fin, p_issues, p_act, p_pre, p_ord, p_dly, bub;
    bit an_h [0:2047];
    bit act_h[0:2047];
    bit pre_h[0:2047];

    task automatic fwd_pass(input bit stall, input bit keep);
        int  et = 0;
        int  ed = 0;
        int  stall_left = 0;
        bit  stalled = 0;
        p_first = -1; p_last = -1; p_start = -1; p_fin = -1;
        p_issues = 0; p_act = 0; p_pre = 0; p_ord = 0; p_dly = 0; bub = -1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            an_h[c]  = bus.active_normal;
            act_h[c] = bus.active;
            pre_h[c] = bus.active_pre;
            if (bus.active_normal) begin
                if (p_first < 0) p_first = c;
                p_last = c;
                p_issues++;
                if (bus.tap_address != 4'(et) || bus.data_read_addr != 6'(ed)) p_ord++;
                if (et == 11) begin et = 0; ed++; end else et++;
            end
            if (bus.active_start_d && p_start < 0) p_start = c;
            if (bus.active) p_act++;
            if (bus.active_pre) p_pre++;
            if (stall_left > 0) begin
                chk("stall_hold_tap", bus.tap_address, 7);
                chk("stall_hold_data", bus.data_read_addr, 10);
                chk("stall_no_issue", bus.active_normal, 0);
                stall_left--;
                if (stall_left == 0) bus.out_rdy = 1'b1;
            end else if (stall && !stalled && bus.active_normal &&
                         bus.tap_address == 4'd7 && bus.data_read_addr == 6'd10) begin
                bus.out_rdy = 1'b0;
                stalled = 1;
                stall_left = 3;
                bub = c + 1;
            end
            if (bus.read_finish) begin
                p_fin = c;
                chk("finish_idle_busy", bus.busy, 0);
                if (!keep) bus.data_ready = 1'b0;
                break;
            end
        end
        chk("pass_finished", p_fin >= 0, 1);
        for (int c = 0; c + 5 <= p_fin; c++) begin
            if (act_h[c+5] != an_h[c]) p_dly++;
            if (pre_h[c+4] != an_h[c]) p_dly++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int found;
        int nf, nl, fe, le, na, ae, ftap0, last_l, efin;
        bus.data_ready  = 1'b0;
        bus.err_ready   = 1'b0;
        bus.out_rdy     = 1'b1;
        bus.error_valid = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_flags", flags(), 0);
        chk("rst_tap", bus.tap_address, 0);
        chk("rst_data", bus.data_read_addr, 0);
        chk("rst_phases", {bus.error_phase, bus.error_phase_read}, 0);

        // 1: reset in the middle of a forward pass at (5,3)
        reset = 1'b1;
        bus.data_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.active_normal && bus.tap_address == 4'd5 && bus.data_read_addr == 6'd3) begin
                found = 1;
                break;
            end
        end
        chk("reach_t5_d3", found, 1);
        reset = 1'b0;
        #1;
        chk("midrst_flags", flags(), 0);
        chk("midrst_tap", bus.tap_address, 0);
        chk("midrst_data", bus.data_read_addr, 0);
        repeat (2) tick();
        reset = 1'b1;

        // 2: full forward pass after restart (data_ready kept high)
        fwd_pass(0, 1);
        chk("p1_first_issue", p_first, 1);
        chk("p1_issues", p_issues, 768);
        chk("p1_order", p_ord, 0);
        chk("p1_start_d_lat", p_start - p_first, 5);
        chk("p1_finish_lat", p_fin - p_last, 6);
        chk("p1_active_cnt", p_act, 768);
        chk("p1_pre_cnt", p_pre, 768);
        chk("p1_delay_lines", p_dly, 0);

        // 3 + 6: back-to-back pass with a 3-cycle stall at (7,10)
        fwd_pass(1, 0);
        chk("p2_back_to_back", p_first, 1);
        chk("p2_issues", p_issues, 768);
        chk("p2_order", p_ord, 0);
        chk("p2_finish_lat", p_fin - p_last, 6);
        chk("p2_stall_seen", bub > 0, 1);
        if (bub > 0)
            chk("p2_active_gap", {act_h[bub+4], act_h[bub+5], act_h[bub+6], act_h[bub+7], act_h[bub+8]}, 5'b10001);
        chk("p2_delay_lines", p_dly, 0);
        tick();
        chk("idle_after_pass", bus.busy, 0);

        // 4: error pass wins over data pass
        bus.err_ready = 1'b1;
        bus.data_ready = 1'b1;
        tick();
        bus.err_ready = 1'b0;
        bus.data_ready = 1'b0;
        nf = 0; nl = 0; fe = 0; le = 0; na = 0; ae = 0; ftap0 = -1; last_l = -1; efin = -1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.active_normal) na++;
            if (bus.active) ae++;
            if (bus.error_update_first) begin
                if (ftap0 < 0) ftap0 = bus.tap_address;
                if (bus.tap_address != 4'(12 + nf) || bus.error_phase_read != 2'(nf)) fe++;
                if (nl != 0) fe++;
                nf++;
            end
            if (bus.error_update_latch) begin
                last_l = c;
                if (!bus.error_update_first) begin
                    if (bus.tap_address != 4'(nl)) le++;
                    nl++;
                end
            end
            if (bus.read_finish) begin
                efin = c;
                break;
            end
        end
        chk("err_first_tap12", ftap0, 12);
        chk("err_first_cnt", nf, 4);
        chk("err_first_seq", fe, 0);
        chk("err_upd_cnt", nl, 12);
        chk("err_upd_seq", le, 0);
        chk("err_issue_cnt", na, 16);
        chk("err_active_masked", ae, 0);
        chk("err_finish_lat", efin - last_l, 6);

        // 5: error_phase counts error_valid in any state
        bus.error_valid = 1'b1; tick(); bus.error_valid = 1'b0;
        chk("ephase_1_idle", bus.error_phase, 1);
        bus.error_valid = 1'b1; bus.err_ready = 1'b1; tick();
        bus.error_valid = 1'b0; bus.err_ready = 1'b0;
        chk("ephase_2", bus.error_phase, 2);
        bus.error_valid = 1'b1; tick(); bus.error_valid = 1'b0;
        chk("ephase_3_busy", {bus.busy, bus.error_phase}, 3'b111);
        bus.error_valid = 1'b1; tick(); bus.error_valid = 1'b0;
        chk("ephase_wrap0", bus.error_phase, 0);
        bus.error_valid = 1'b1; tick(); bus.error_valid = 1'b0;
        chk("ephase_1_again", bus.error_phase, 1);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.read_finish) begin
                found = 1;
                break;
            end
        end
        chk("ephase_pass_done", found, 1);
        chk("ephase_hold", bus.error_phase, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
